// File: rtl/fft_reorder_pkg.sv
// Shared definitions for the FFT output reorder buffer: read latency and the
// bit-reversal helper used to form natural-order read addresses.
package fft_reorder_pkg;

    localparam int RD_LATENCY = 2;
    localparam int MAX_LOG2N  = 12;

    // Reverses the low 'bits' bits of value; the upper bits of the result are zero.
    function automatic logic [MAX_LOG2N-1:0] bit_reverse(input logic [MAX_LOG2N-1:0] value,
                                                         input int bits);
        logic [MAX_LOG2N-1:0] r;
        for (int i = 0; i < MAX_LOG2N; i++) r[i] = value[MAX_LOG2N-1-i];
        return r >> (MAX_LOG2N - bits);
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Simple dual-port RAM holding both ping-pong banks; the bank select is the
// address MSB. One write port, one registered read port.
module fft_pingpong_ram #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values; the memory array has no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (rd) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_reorder_buf.sv
// Ping-pong reorder buffer: writes frames in arrival order, reads them back in
// bit-reversed (or write) order, with frame-start markers and abort detection.
module fft_reorder_buf
    import fft_reorder_pkg::*;
#(
    parameter int LOG2N = 8,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic             di_sof,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    input  logic             bitrev,
    output logic             do_en,
    output logic             do_sof,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             frame_err
);

    localparam int N = 1 << LOG2N;

    typedef logic [LOG2N-1:0] addr_t;
    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } sample_t;

    localparam addr_t LAST = addr_t'(N - 1);

    addr_t   wr_cnt, rd_cnt, wr_addr, rd_addr;
    logic    wb, rb, dropping;
    logic    [1:0] full, mode;
    logic    frame_start, abort, blocked, we, rd_issue;
    logic    [RD_LATENCY-1:0] vpipe, spipe;
    sample_t wr_word, rd_word;

    // A frame starts on an explicit marker or when the counter wraps to 0.
    assign frame_start = di_en && (di_sof || wr_cnt == '0);
    assign abort       = di_en && di_sof && wr_cnt != '0;
    assign wr_addr     = frame_start ? '0 : wr_cnt;
    assign blocked     = frame_start ? full[wb] : dropping;
    assign we          = di_en && !blocked;
    assign wr_word     = '{re: di_re, im: di_im};

    assign rd_issue = full[rb];
    assign rd_addr  = mode[rb] ? addr_t'(bit_reverse(MAX_LOG2N'(rd_cnt), LOG2N)) : rd_cnt;

    fft_pingpong_ram #(
        .AW (LOG2N + 1),
        .DW ($bits(sample_t))
    ) u_ram (
        .clock (clock),
        .we    (we),
        .waddr ({wb, wr_addr}),
        .wdata (wr_word),
        .rd    (rd_issue),
        .raddr ({rb, rd_addr}),
        .rdata (rd_word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            wb        <= 1'b0;
            rb        <= 1'b0;
            full      <= '0;
            mode      <= '0;
            dropping  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort || (frame_start && full[wb]);
            // Reader clears before writer sets; they never target the same bank.
            if (rd_issue) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt == LAST) begin
                    full[rb] <= 1'b0;
                    rb       <= ~rb;
                end
            end
            if (di_en) begin
                if (frame_start) begin
                    dropping <= full[wb];
                    if (!full[wb]) mode[wb] <= bitrev;
                end
                if (wr_addr == LAST) begin
                    wr_cnt   <= '0;
                    dropping <= 1'b0;
                    if (!blocked) begin
                        full[wb] <= 1'b1;
                        wb       <= ~wb;
                    end
                end else begin
                    wr_cnt <= wr_addr + 1'b1;
                end
            end
        end
    end

    assign do_en  = vpipe[RD_LATENCY-1];
    assign do_sof = spipe[RD_LATENCY-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vpipe <= '0;
            spipe <= '0;
            do_re <= '0;
            do_im <= '0;
        end else begin
            vpipe <= {vpipe[RD_LATENCY-2:0], rd_issue};
            spipe <= {spipe[RD_LATENCY-2:0], rd_issue && rd_cnt == '0};
            if (vpipe[RD_LATENCY-2]) begin
                do_re <= rd_word.re;
                do_im <= rd_word.im;
            end
        end
    end

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Self-checking bench for fft_reorder_buf: a frame-level reference model feeds
// an expected-output queue that a negedge compare process checks every cycle.
module tb_fft_reorder_buf;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    // LOG2N=8, WIDTH=16 instance
    logic        di_en = 0, di_sof = 0, bitrev = 0;
    logic [15:0] di_re = '0, di_im = '0;
    logic        do_en, do_sof, frame_err;
    logic [15:0] do_re, do_im;

    // LOG2N=4, WIDTH=24 instance
    logic        s_di_en = 0, s_di_sof = 0, s_bitrev = 0;
    logic [23:0] s_di_re = '0, s_di_im = '0;
    logic        s_do_en, s_do_sof, s_frame_err;
    logic [23:0] s_do_re, s_do_im;

    fft_reorder_buf #(.LOG2N(8), .WIDTH(16)) dut (
        .clock(clock), .reset(reset), .di_en(di_en), .di_sof(di_sof),
        .di_re(di_re), .di_im(di_im), .bitrev(bitrev), .do_en(do_en),
        .do_sof(do_sof), .do_re(do_re), .do_im(do_im), .frame_err(frame_err)
    );

    fft_reorder_buf #(.LOG2N(4), .WIDTH(24)) dut_s (
        .clock(clock), .reset(reset), .di_en(s_di_en), .di_sof(s_di_sof),
        .di_re(s_di_re), .di_im(s_di_im), .bitrev(s_bitrev), .do_en(s_do_en),
        .do_sof(s_do_sof), .do_re(s_do_re), .do_im(s_do_im), .frame_err(s_frame_err)
    );

    // cyc equals the number of the rising edge most recently applied.
    initial forever begin
        #5 clock = 1'b1;
        cyc++;
        #5 clock = 1'b0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        sof;
        logic [23:0] re;
        logic [23:0] im;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];

    function automatic int brev(input int k, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) if ((k >> i) & 1) r |= 1 << (bits - 1 - i);
        return r;
    endfunction

    // Frame model: sample n carries re=n+off, im=max-re; output k is sample brev(k) or k.
    task automatic push8(input logic bm, input int off);
        for (int k = 0; k < 256; k++) begin
            exp_t e;
            int   v;
            v     = ((bm ? brev(k, 8) : k) + off) & 32'hFFFF;
            e.sof = (k == 0);
            e.re  = 24'(v);
            e.im  = 24'(32'hFFFF - v);
            q8.push_back(e);
        end
    endtask

    task automatic push4(input logic bm);
        for (int k = 0; k < 16; k++) begin
            exp_t e;
            int   v;
            v     = bm ? brev(k, 4) : k;
            e.sof = (k == 0);
            e.re  = 24'(v);
            e.im  = 24'(32'hFFFFFF - v);
            q4.push_back(e);
        end
    endtask

    // Compare process and output bookkeeping
    int          cur_run8 = 0, last_run8 = 0, runs8 = 0, first_on8 = 0;
    int          cur_run4 = 0, last_run4 = 0, first_on4 = 0;
    int          err_pulses = 0, err_cycles = 0;
    logic        err_prev = 0;
    logic [15:0] obs8 [1024];
    logic [23:0] obs4 [16];

    always @(negedge clock) begin
        if (frame_err) err_cycles++;
        if (frame_err && !err_prev) err_pulses++;
        err_prev = frame_err;
        check("small_frame_err", s_frame_err, 1'b0);

        if (do_en) begin
            if (cur_run8 == 0) first_on8 = cyc;
            if (q8.size() == 0) check("out8_unexpected", do_en, 1'b0);
            else begin
                exp_t e;
                e = q8.pop_front();
                check("out8", {do_sof, 24'(do_re), 24'(do_im)}, {e.sof, e.re, e.im});
            end
            obs8[cur_run8 % 1024] = do_re;
            cur_run8++;
        end else if (cur_run8 > 0) begin
            last_run8 = cur_run8;
            runs8++;
            cur_run8 = 0;
        end

        if (s_do_en) begin
            if (cur_run4 == 0) first_on4 = cyc;
            if (q4.size() == 0) check("out4_unexpected", s_do_en, 1'b0);
            else begin
                exp_t e;
                e = q4.pop_front();
                check("out4", {s_do_sof, s_do_re, s_do_im}, {e.sof, e.re, e.im});
            end
            obs4[cur_run4 % 16] = s_do_re;
            cur_run4++;
        end else if (cur_run4 > 0) begin
            last_run4 = cur_run4;
            cur_run4 = 0;
        end
    end

    // Stimulus: inputs change 1 time unit after a rising edge.
    int last_edge8 = 0, last_edge4 = 0;

    task automatic put8(input logic en, input logic sof, input logic bm, input int v);
        di_en  = en;
        di_sof = sof;
        bitrev = bm;
        di_re  = 16'(v);
        di_im  = 16'(32'hFFFF - v);
        @(posedge clock);
        if (en) last_edge8 = cyc;
        #1;
        di_en  = 1'b0;
        di_sof = 1'b0;
    endtask

    // Samples after the first drive the opposite bitrev so only the first one matters.
    task automatic frame8(input logic bm, input int off, input int gap, input int count);
        for (int n = 0; n < count; n++) begin
            put8(1'b1, n == 0, n == 0 ? bm : ~bm, (n + off) & 32'hFFFF);
            repeat (gap) put8(1'b0, 1'b0, ~bm, 0);
        end
    endtask

    task automatic frame4(input logic bm);
        for (int n = 0; n < 16; n++) begin
            s_di_en  = 1'b1;
            s_di_sof = (n == 0);
            s_bitrev = n == 0 ? bm : ~bm;
            s_di_re  = 24'(n);
            s_di_im  = 24'(32'hFFFFFF - n);
            @(posedge clock);
            last_edge4 = cyc;
            #1;
        end
        s_di_en  = 1'b0;
        s_di_sof = 1'b0;
    endtask

    task automatic wait_idle8();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            #1;
            if (!do_en && q8.size() == 0 && cur_run8 == 0) return;
        end
        check("idle8_timeout", q8.size(), 0);
    endtask

    task automatic wait_idle4();
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            #1;
            if (!s_do_en && q4.size() == 0 && cur_run4 == 0) return;
        end
        check("idle4_timeout", q4.size(), 0);
    endtask

    initial begin
        int e0, c0, r0;

        #12;
        check("rst_do_en", do_en, 1'b0);
        check("rst_do_sof", do_sof, 1'b0);
        check("rst_do_re", do_re, 16'h0);
        check("rst_do_im", do_im, 16'h0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_s_do_en", s_do_en, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;

        // Bit-reversed ramp
        e0 = err_pulses;
        frame8(1'b1, 0, 0, 256);
        push8(1'b1, 0);
        wait_idle8();
        check("brev_latency", first_on8, last_edge8 + 2);
        check("brev_run_len", last_run8, 256);
        check("brev_k0", obs8[0], 16'h00);
        check("brev_k1", obs8[1], 16'h80);
        check("brev_k2", obs8[2], 16'h40);
        check("brev_k3", obs8[3], 16'hC0);
        check("brev_k255", obs8[255], 16'hFF);
        check("brev_no_err", err_pulses, e0);

        // Bypass ramp
        frame8(1'b0, 0, 0, 256);
        push8(1'b0, 0);
        wait_idle8();
        check("byp_k1", obs8[1], 16'h01);
        check("byp_k200", obs8[200], 16'hC8);
        check("byp_run_len", last_run8, 256);

        // Three back-to-back frames with alternating modes
        e0 = err_pulses;
        r0 = runs8;
        frame8(1'b1, 16'h000, 0, 256);
        push8(1'b1, 16'h000);
        frame8(1'b0, 16'h100, 0, 256);
        push8(1'b0, 16'h100);
        frame8(1'b1, 16'h200, 0, 256);
        push8(1'b1, 16'h200);
        wait_idle8();
        check("b2b_run_len", last_run8, 768);
        check("b2b_one_run", runs8 - r0, 1);
        check("b2b_no_err", err_pulses, e0);
        check("b2b_f1_k257", obs8[257], 16'h101);
        check("b2b_f2_k513", obs8[513], 16'h280);

        // Gapped input: 1 on / 2 off
        frame8(1'b1, 0, 2, 256);
        push8(1'b1, 0);
        wait_idle8();
        check("gap_run_len", last_run8, 256);
        check("gap_k1", obs8[1], 16'h80);

        // Frame aborted at n=100 by a new start marker
        e0 = err_pulses;
        c0 = err_cycles;
        frame8(1'b1, 16'h300, 0, 100);
        frame8(1'b1, 16'h300, 0, 256);
        push8(1'b1, 16'h300);
        wait_idle8();
        check("abort_pulses", err_pulses - e0, 1);
        check("abort_pulse_len", err_cycles - c0, 1);
        check("abort_run_len", last_run8, 256);
        check("abort_k1", obs8[1], 16'h380);

        // Reset during readout at k=50
        frame8(1'b1, 16'h400, 0, 256);
        push8(1'b1, 16'h400);
        for (int i = 0; i < 1000 && cur_run8 != 51; i++) begin
            @(negedge clock);
            #1;
        end
        check("rst_mid_reached_k50", cur_run8, 51);
        reset = 1'b1;
        #1;
        check("rst_mid_do_en", do_en, 1'b0);
        q8.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("rst_mid_quiet", do_en, 1'b0);
        frame8(1'b0, 16'h500, 0, 256);
        push8(1'b0, 16'h500);
        wait_idle8();
        check("rst_mid_run_len", last_run8, 256);
        check("rst_mid_k255", obs8[255], 16'h5FF);

        // 16-point, 24-bit build
        frame4(1'b1);
        push4(1'b1);
        wait_idle4();
        check("small_latency", first_on4, last_edge4 + 2);
        check("small_run_len", last_run4, 16);
        check("small_k0", obs4[0], 24'd0);
        check("small_k1", obs4[1], 24'd8);
        check("small_k15", obs4[15], 24'd15);

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
